// File: rtl/time_counter_24h_if.sv
// Control and BCD time bus of the 24h time counter.
interface time_counter_24h_if;
  logic       run;
  logic       inc_min;
  logic       inc_hour;
  logic       clr_sec;
  logic [3:0] bcd_ht;
  logic [3:0] bcd_hu;
  logic [3:0] bcd_mt;
  logic [3:0] bcd_mu;
  logic [3:0] bcd_st;
  logic [3:0] bcd_su;
  logic       sec_tick;
  logic       hour_strobe;

  modport master (
    output run, inc_min, inc_hour, clr_sec,
    input  bcd_ht, bcd_hu, bcd_mt, bcd_mu, bcd_st, bcd_su, sec_tick, hour_strobe
  );

  modport slave (
    input  run, inc_min, inc_hour, clr_sec,
    output bcd_ht, bcd_hu, bcd_mt, bcd_mu, bcd_st, bcd_su, sec_tick, hour_strobe
  );
endinterface

// File: rtl/time_counter_24h.sv
// 24-hour BCD hh:mm:ss timekeeper with 1 Hz prescaler and manual adjust.
module time_counter_24h #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input logic               clk,
  input logic               rst_n,
  time_counter_24h_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    ht_q, hu_q, mt_q, mu_q, st_q, su_q;
  logic [3:0]    ht_d, hu_d, mt_d, mu_d, st_d, su_d;
  logic          sec_tick_q, hour_strobe_q;
  logic          tick, sec_adv, carry_s, carry_m, wrap_m;

  // Prescaler and the seconds/minutes/hours cascade, resolved in one cycle.
  always_comb begin
    presc_d = presc_q;
    su_d    = su_q;
    st_d    = st_q;
    mu_d    = mu_q;
    mt_d    = mt_q;
    hu_d    = hu_q;
    ht_d    = ht_q;
    carry_s = 1'b0;
    wrap_m  = 1'b0;

    tick    = bus.run && (presc_q == PRESC_MAX);
    sec_adv = tick && !bus.clr_sec;

    if (bus.clr_sec) begin
      presc_d = '0;
    end else if (bus.run) begin
      presc_d = tick ? '0 : PW'(presc_q + 1'b1);
    end

    if (bus.clr_sec) begin
      su_d = 4'd0;
      st_d = 4'd0;
    end else if (sec_adv) begin
      if (su_q == 4'd9) begin
        su_d = 4'd0;
        if (st_q == 4'd5) begin
          st_d    = 4'd0;
          carry_s = 1'b1;
        end else begin
          st_d = 4'(st_q + 4'd1);
        end
      end else begin
        su_d = 4'(su_q + 4'd1);
      end
    end

    // A carry and a manual pulse in the same cycle merge into one step.
    if (carry_s || bus.inc_min) begin
      if (mu_q == 4'd9) begin
        mu_d = 4'd0;
        if (mt_q == 4'd5) begin
          mt_d   = 4'd0;
          wrap_m = 1'b1;
        end else begin
          mt_d = 4'(mt_q + 4'd1);
        end
      end else begin
        mu_d = 4'(mu_q + 4'd1);
      end
    end

    // Only a seconds-driven minute wrap propagates into the hours.
    carry_m = carry_s && wrap_m;

    if (carry_m || bus.inc_hour) begin
      if (ht_q == 4'd2 && hu_q == 4'd3) begin
        ht_d = 4'd0;
        hu_d = 4'd0;
      end else if (hu_q == 4'd9) begin
        hu_d = 4'd0;
        ht_d = 4'(ht_q + 4'd1);
      end else begin
        hu_d = 4'(hu_q + 4'd1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      ht_q          <= 4'd0;
      hu_q          <= 4'd0;
      mt_q          <= 4'd0;
      mu_q          <= 4'd0;
      st_q          <= 4'd0;
      su_q          <= 4'd0;
      sec_tick_q    <= 1'b0;
      hour_strobe_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      ht_q          <= ht_d;
      hu_q          <= hu_d;
      mt_q          <= mt_d;
      mu_q          <= mu_d;
      st_q          <= st_d;
      su_q          <= su_d;
      sec_tick_q    <= sec_adv;
      hour_strobe_q <= carry_m;
    end
  end

  assign bus.bcd_ht      = ht_q;
  assign bus.bcd_hu      = hu_q;
  assign bus.bcd_mt      = mt_q;
  assign bus.bcd_mu      = mu_q;
  assign bus.bcd_st      = st_q;
  assign bus.bcd_su      = su_q;
  assign bus.sec_tick    = sec_tick_q;
  assign bus.hour_strobe = hour_strobe_q;

endmodule

// File: tb/tb_time_counter_24h.sv
// Scoreboard bench for time_counter_24h: seconds-of-day reference model.
module tb_time_counter_24h;

  localparam int TD = 4;

  typedef struct {
    int h;
    int m;
    int s;
    bit stk;
    bit hs;
  } exp_t;

  logic clk;
  logic rst_n;
  time_counter_24h_if bus ();

  time_counter_24h #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_tod   = 0;
  int   m_presc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] dut_time();
    return {bus.bcd_ht, bus.bcd_hu, bus.bcd_mt, bus.bcd_mu, bus.bcd_st, bus.bcd_su};
  endfunction

  // Monitor: compare every registered output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("time", dut_time(), to_bcd(e.h, e.m, e.s));
        check("sec_tick", 24'(bus.sec_tick), 24'(e.stk));
        check("hour_strobe", 24'(bus.hour_strobe), 24'(e.hs));
      end
    end
  end

  // Drive one cycle, advance the model and queue the post-edge expectation.
  task automatic step(input bit r, input bit im, input bit ih, input bit cs);
    int   s, m, h;
    bit   tick, carry_s, carry_m;
    exp_t e;
    bus.run      = r;
    bus.inc_min  = im;
    bus.inc_hour = ih;
    bus.clr_sec  = cs;
    tick    = r && (m_presc == TD - 1);
    s       = m_tod % 60;
    m       = (m_tod / 60) % 60;
    h       = m_tod / 3600;
    carry_s = 1'b0;
    carry_m = 1'b0;
    if (cs) m_presc = 0;
    else if (r) m_presc = (m_presc + 1) % TD;
    if (cs) s = 0;
    else if (tick) begin
      s++;
      if (s == 60) begin
        s = 0;
        carry_s = 1'b1;
      end
    end
    if (carry_s || im) begin
      m++;
      if (m == 60) begin
        m = 0;
        carry_m = carry_s;
      end
    end
    if (carry_m || ih) h = (h + 1) % 24;
    m_tod = h * 3600 + m * 60 + s;
    e = '{h: h, m: m, s: s, stk: tick && !cs, hs: carry_m};
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  // Run until the model reaches the given second and prescaler phase.
  task automatic run_until(input int sec, input int presc);
    int n = 0;
    while (!((m_tod % 60) == sec && m_presc == presc)) begin
      if (n >= 2000) begin
        checks++;
        errors++;
        $display("FAIL run_until: got sec %0d presc %0d expected sec %0d presc %0d", m_tod % 60, m_presc, sec, presc);
        break;
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
  endtask

  // Assert reset between edges and check that outputs clear without a clock.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_time", dut_time(), 24'h000000);
    check("reset_sec_tick", 24'(bus.sec_tick), 24'h0);
    check("reset_hour_strobe", 24'(bus.hour_strobe), 24'h0);
    m_tod   = 0;
    m_presc = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic preload(input int h, input int m);
    for (int i = 0; i < h; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < m; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bus.run      = 1'b0;
    bus.inc_min  = 1'b0;
    bus.inc_hour = 1'b0;
    bus.clr_sec  = 1'b0;
    rst_n        = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("por_time", dut_time(), 24'h000000);
    check("por_sec_tick", 24'(bus.sec_tick), 24'h0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Free run: ticks at cycles 4 and 8.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Full cascade 23:59:59 -> 00:00:00.
    async_reset();
    preload(23, 59);
    for (int i = 0; i < 60 * TD + 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Manual adjust while frozen: 10:59:30 -> 10:00:30 -> 00:00:30.
    async_reset();
    preload(10, 59);
    run_until(30, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    preload(14, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Tick and inc_min together at :59.
    run_until(59, TD - 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // clr_sec colliding with a tick at 00:00:59.
    async_reset();
    run_until(59, TD - 1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < TD + 1; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Freeze mid-second, then resume on the remaining count.
    run_until(3, 2);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Async reset at 12:34:56 mid-second, then count from phase 0.
    preload(12, 34);
    run_until(56, 2);
    async_reset();
    for (int i = 0; i < TD + 1; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Random mix near hour boundaries and elsewhere.
    for (int blk = 0; blk < 6; blk++) begin
      async_reset();
      preload(int'($urandom_range(0, 23)), int'($urandom_range(55, 59)));
      for (int i = 0; i < 500; i++)
        step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 39) == 0, $urandom_range(0, 49) == 0);
    end

    repeat (2) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_counter_24h.md
Name: time_counter_24h

Overview:
- Timekeeping core of the digital clock: divides the system clock down to a 1 Hz tick and maintains a BCD hh:mm:ss counter in 24-hour format.
- Hour digits feed the 24h-to-12h hour converter directly downstream; minute and second digits go straight to the display mux.
- Provides manual minute/hour adjust and a seconds clear for time setting.

Parameters:
- TICK_DIV, 50000000, system clock cycles per second tick; legal range >= 1; sim benches use 4.
- PW, $clog2(TICK_DIV) (min 1), prescaler width; derived, not overridden.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- run  input  1  1 = prescaler counts and time advances; 0 = time frozen (adjust still works)
- inc_min  input  1  single-cycle pulse: advance minutes by 1
- inc_hour  input  1  single-cycle pulse: advance hours by 1
- clr_sec  input  1  single-cycle pulse: seconds to 00, prescaler to 0
- bcd_ht  output  4  hour tens, 0..2
- bcd_hu  output  4  hour units, 0..9 (0..3 when bcd_ht=2)
- bcd_mt  output  4  minute tens, 0..5
- bcd_mu  output  4  minute units, 0..9
- bcd_st  output  4  second tens, 0..5
- bcd_su  output  4  second units, 0..9
- sec_tick  output  1  one-cycle pulse, same cycle the seconds register updates from the prescaler
- hour_strobe  output  1  one-cycle pulse on natural rollover xx:59:59 -> (xx+1):00:00

Behaviour:
- Reset (rst_n=0, async): prescaler=0, all digits 0 (00:00:00), sec_tick=0, hour_strobe=0. All outputs are registered.
- Prescaler:
  - When run=1, counts 0..TICK_DIV-1.
  - At TICK_DIV-1 it wraps to 0 and asserts internal tick; sec_tick is the registered copy, aligned with the digit update.
  - run=0 holds the prescaler value, so no partial-second loss on resume.
  - TICK_DIV=1: tick on every run cycle.
- Seconds:
  - On tick, su increments; su 9 -> 0 with st+1; st:su 59 -> 00 raises carry_s.
- Minutes: advance by exactly 1 when (carry_s OR inc_min).
  - Simultaneous carry_s and inc_min yields one increment, not two.
  - 59 -> 00 raises carry_m only when carry_s caused the advance. Manual inc_min at 59 wraps to 00 without touching hours.
- Hours: advance by exactly 1 when (carry_m OR inc_hour); simultaneous events yield one increment.
  - Sequence 09 -> 10, 19 -> 20, 23 -> 00.
  - Manual inc_hour follows the same wrap.
- hour_strobe asserts only when carry_m caused the hour advance; never on inc_hour or inc_min.
- clr_sec:
  - Highest priority for seconds and prescaler: digits go to 00 and prescaler to 0.
  - A tick in the same cycle is discarded: no carry_s, no sec_tick.
  - Minutes and hours are unaffected except by a concurrent inc_min or inc_hour.
- Adjust inputs act regardless of run. Held-high inputs increment once per cycle; edge detection is upstream.
- All updates happen in one cycle: a full cascade 23:59:59 -> 00:00:00 completes on the tick cycle.
- No illegal BCD value is ever produced, including after any mix of simultaneous events.
- Reset mid-second: the prescaler phase is lost and counting restarts from 0 after release.

Test Plan:
- TICK_DIV=4, reset release, run=1, 8 cycles -> sec_tick at cycles 4 and 8; time 00:00:02; no hour_strobe.
- Preload via inc_hour x23 and inc_min x59, then run to 60 ticks -> 23:59:59 becomes 00:00:00 in one cycle; hour_strobe high exactly that cycle.
- At 10:59:30, run=0, pulse inc_min -> 10:00:30 (no hour carry); pulse inc_hour x14 -> 00:00:30; hour_strobe never asserted.
- At xx:mm:59 with tick and inc_min in the same cycle -> minutes +1 only; seconds 00.
- clr_sec in the same cycle as tick at 00:00:59 -> 00:00:00; no sec_tick; minutes unchanged; next tick after 4 cycles.
- Async reset asserted mid-count at 12:34:56 between edges -> outputs 00:00:00 immediately, before the next clk edge; run=0 freeze check: prescaler value held, tick resumes on the remaining count.
